// File: rtl/rank_pkg.sv
// Shared types and pass/timing helpers for the rank (order-statistic) filter.
package rank_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

  // Extraction passes needed for rank k: sweep from whichever end is closer.
  function automatic int n_passes(int k, int len);
    return (k <= (len - 1) / 2) ? k + 1 : len - k;
  endfunction

  function automatic int sort_cycles(int k, int len);
    int p;
    p = n_passes(k, len);
    return p * len - (p * (p - 1)) / 2;
  endfunction

endpackage

// File: rtl/rank_cmp_swap.sv
// Single compare-swap unit: keeps the running extreme of a sweep in a register and
// hands the loser back combinationally so it can be written into the buffer.
module rank_cmp_swap
  import rank_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            maxMode_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [SIZE-1:0] sample_i,
  output logic [SIZE-1:0] win_o,
  output logic [SIZE-1:0] pass_o
);

  logic [SIZE-1:0] keep_q;
  logic            sampleWins;

  always_comb begin
    sampleWins = maxMode_i ? (sample_i > keep_q) : (sample_i < keep_q);
    win_o      = (load_i || sampleWins) ? sample_i : keep_q;
    pass_o     = sampleWins ? keep_q : sample_i;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      keep_q <= '0;
    end else if (en_i) begin
      keep_q <= win_o;
    end
  end

endmodule

// File: rtl/rank_filter.sv
// Streaming order-statistic filter: loads LENGTH samples, then runs repeated
// min- or max-extraction sweeps through one compare-swap unit to find rank RANK.
module rank_filter
  import rank_pkg::*;
#(
  parameter  int SIZE   = 8,
  parameter  int LENGTH = 9,
  localparam int RW     = $clog2(LENGTH)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [SIZE-1:0] DI,
  input  logic            DSI,
  input  logic [RW-1:0]   RANK,
  output logic [SIZE-1:0] DO,
  output logic            DSO,
  output logic            BUSY,
  output logic            OVR
);

  localparam logic [RW-1:0] LAST = RW'(LENGTH - 1);
  localparam logic [RW-1:0] HALF = RW'((LENGTH - 1) / 2);
  localparam logic [RW-1:0] ONE  = RW'(1);

  state_t          state_q, state_d;
  logic [SIZE-1:0] buf_q [LENGTH];
  logic [SIZE-1:0] do_q;
  logic [RW-1:0]   idx_q, pass_q, lastPass_q, lastPass_d;
  logic [RW-1:0]   rankClamp, passEndIdx;
  logic            maxMode_q, dsiPrev_q;
  logic            start, sortStep, passEnd, sortDone;
  logic [SIZE-1:0] win, passOn;
  int              nPass;

  // Windows open only on a DSI rising edge, so a strobe held past LENGTH samples never reloads.
  always_comb begin
    rankClamp  = (RANK > LAST) ? LAST : RANK;
    nPass      = n_passes(int'(rankClamp), LENGTH);
    lastPass_d = RW'(nPass - 1);
    start      = DSI && !dsiPrev_q;
    passEndIdx = LAST - pass_q;
    sortStep   = (state_q == SORT);
    passEnd    = (idx_q == passEndIdx);
    sortDone   = sortStep && passEnd && (pass_q == lastPass_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD: begin
        if (!DSI)               state_d = IDLE;
        else if (idx_q == LAST) state_d = SORT;
      end
      SORT:    if (sortDone) state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  rank_cmp_swap #(.SIZE(SIZE)) u_cmp (
    .CLK       (CLK),
    .nRST      (nRST),
    .maxMode_i (maxMode_q),
    .load_i    (idx_q == '0),
    .en_i      (sortStep),
    .sample_i  (buf_q[idx_q]),
    .win_o     (win),
    .pass_o    (passOn)
  );

  // Each sweep shifts losers down one slot and parks the extreme at the end of the live region.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dsiPrev_q  <= 1'b0;
      do_q       <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      lastPass_q <= '0;
      maxMode_q  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) buf_q[i] <= '0;
    end else begin
      dsiPrev_q <= DSI;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            buf_q[0]   <= DI;
            idx_q      <= ONE;
            lastPass_q <= lastPass_d;
            maxMode_q  <= (rankClamp > HALF);
          end
        end
        LOAD: begin
          if (DSI) begin
            buf_q[idx_q] <= DI;
            idx_q        <= (idx_q == LAST) ? '0 : idx_q + ONE;
            pass_q       <= '0;
          end
        end
        SORT: begin
          if (idx_q != '0) buf_q[idx_q - ONE] <= passOn;
          if (passEnd) begin
            buf_q[passEndIdx] <= win;
            idx_q             <= '0;
            pass_q            <= pass_q + ONE;
            if (pass_q == lastPass_q) do_q <= win;
          end else begin
            idx_q <= idx_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign DO   = do_q;
  assign DSO  = (state_q == DONE);
  assign BUSY = (state_q == LOAD) || (state_q == SORT);
  assign OVR  = (state_q == SORT) && start;

endmodule

// File: tb/tb_rank_filter.sv
// Directed bench for rank_filter: table of full windows plus hand-written
// abort / overrun / held-strobe / reset / back-to-back sequences.
module tb_rank_filter;

  typedef struct {
    logic [71:0] s;
    logic [3:0]  rank;
    logic [7:0]  expDo;
    int          expLat;
  } vec_t;

  logic       CLK;
  logic       nRST;
  logic [7:0] DI;
  logic       DSI;
  logic [3:0] RANK;
  logic [7:0] DO;
  logic       DSO, BUSY, OVR;

  int nApplied    = 0;
  int nMiscompare = 0;

  rank_filter #(.SIZE(8), .LENGTH(9)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .RANK (RANK),
    .DO   (DO),
    .DSO  (DSO),
    .BUSY (BUSY),
    .OVR  (OVR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives samples from..8 of a window, first listed sample first.
  task automatic applyStimulus(input logic [71:0] s, input logic [3:0] r, input int from);
    for (int i = from; i < 9; i++) begin
      @(negedge CLK);
      DSI  = 1'b1;
      DI   = s[71 - 8*i -: 8];
      RANK = r;
    end
  endtask

  task automatic awaitResult(input string name, input logic [7:0] expDo, input int expLat);
    int         found;
    logic [7:0] got;
    found = 0;
    got   = '0;
    for (int m = 1; m <= expLat + 8 && found == 0; m++) begin
      @(negedge CLK);
      if (m == 1) DSI = 1'b0;
      if (DSO) begin
        found = m;
        got   = DO;
      end
    end
    checkOutput({name, " latency"}, found, expLat);
    checkOutput({name, " DO"}, {24'd0, got}, {24'd0, expDo});
    @(negedge CLK);
    checkOutput({name, " DSO/BUSY after"}, {30'd0, DSO, BUSY}, 32'd0);
  endtask

  function automatic vec_t mkVec(logic [71:0] s, logic [3:0] r, logic [7:0] d, int l);
    vec_t v;
    v.s      = s;
    v.rank   = r;
    v.expDo  = d;
    v.expLat = l;
    return v;
  endfunction

  vec_t        vecs[13];
  logic [71:0] down, mixed, same, alt;
  int          found, dsoCount;
  logic [7:0]  got;

  initial begin
    down  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    mixed = {8'd200, 8'd17, 8'd99, 8'd3, 8'd250, 8'd42, 8'd42, 8'd7, 8'd128};
    same  = {9{8'd42}};
    alt   = {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
    vecs[0]  = mkVec(down,  4'd4,  8'd5,   36);
    vecs[1]  = mkVec(mixed, 4'd0,  8'd3,   10);
    vecs[2]  = mkVec(mixed, 4'd8,  8'd250, 10);
    vecs[3]  = mkVec(same,  4'd4,  8'd42,  36);
    vecs[4]  = mkVec(same,  4'd15, 8'd42,  10);
    vecs[5]  = mkVec(mixed, 4'd4,  8'd42,  36);
    vecs[6]  = mkVec(mixed, 4'd2,  8'd17,  25);
    vecs[7]  = mkVec(mixed, 4'd6,  8'd128, 25);
    vecs[8]  = mkVec(mixed, 4'd5,  8'd99,  31);
    vecs[9]  = mkVec(down,  4'd1,  8'd2,   18);
    vecs[10] = mkVec(alt,   4'd3,  8'd0,   31);
    vecs[11] = mkVec(alt,   4'd4,  8'd128, 36);
    vecs[12] = mkVec(alt,   4'd7,  8'd255, 18);

    nRST = 1'b0;
    DSI  = 1'b0;
    DI   = '0;
    RANK = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset outputs", {20'd0, DO, DSO, BUSY, OVR}, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].s, vecs[v].rank, 0);
      awaitResult($sformatf("vec%0d", v), vecs[v].expDo, vecs[v].expLat);
    end

    // Abort: strobe drops after four samples.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      DSI = 1'b1;
      DI  = 8'd100 + 8'(i);
      RANK = 4'd4;
    end
    @(negedge CLK);
    DSI = 1'b0;
    checkOutput("abort BUSY in LOAD", {31'd0, BUSY}, 32'd1);
    @(negedge CLK);
    checkOutput("abort BUSY after", {31'd0, BUSY}, 32'd0);
    dsoCount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DSO) dsoCount++;
    end
    checkOutput("abort no DSO", dsoCount, 0);
    applyStimulus(down, 4'd4, 0);
    awaitResult("after abort", 8'd5, 36);

    // Strobe held past the window: extra samples ignored, no reload at DONE.
    applyStimulus(down, 4'd0, 0);
    found = 0;
    got   = '0;
    for (int m = 1; m <= 14; m++) begin
      @(negedge CLK);
      DI = 8'd0;
      if (DSO && found == 0) begin
        found = m;
        got   = DO;
      end
      if (m == 12) checkOutput("held DSI no reload", {31'd0, BUSY}, 32'd0);
    end
    DSI = 1'b0;
    checkOutput("held latency", found, 10);
    checkOutput("held DO", {24'd0, got}, 32'd1);
    @(negedge CLK);

    // Overrun: DSI rises mid-sort.
    applyStimulus(mixed, 4'd4, 0);
    found = 0;
    got   = '0;
    for (int m = 1; m <= 45 && found == 0; m++) begin
      @(negedge CLK);
      if (m == 1) DSI = 1'b0;
      if (m == 5) begin
        DSI = 1'b1;
        DI  = 8'd255;
        #1;
        checkOutput("OVR pulse", {31'd0, OVR}, 32'd1);
      end
      if (m == 6) checkOutput("OVR single cycle", {31'd0, OVR}, 32'd0);
      if (m == 8) DSI = 1'b0;
      if (DSO) begin
        found = m;
        got   = DO;
      end
    end
    checkOutput("OVR latency", found, 36);
    checkOutput("OVR DO", {24'd0, got}, 32'd42);
    @(negedge CLK);

    // Reset in the middle of a sort.
    applyStimulus(down, 4'd4, 0);
    for (int m = 1; m <= 10; m++) begin
      @(negedge CLK);
      if (m == 1) DSI = 1'b0;
    end
    checkOutput("BUSY in SORT", {31'd0, BUSY}, 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("mid-sort reset", {20'd0, DO, DSO, BUSY, OVR}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    dsoCount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DSO) dsoCount++;
    end
    checkOutput("reset no DSO", dsoCount, 0);

    // Back-to-back windows, second one starting in the DONE cycle.
    applyStimulus(mixed, 4'd0, 0);
    for (int m = 1; m <= 10; m++) begin
      @(negedge CLK);
      if (m == 1) DSI = 1'b0;
      if (m == 10) begin
        checkOutput("b2b first DSO", {31'd0, DSO}, 32'd1);
        checkOutput("b2b first DO", {24'd0, DO}, 32'd3);
        DSI  = 1'b1;
        DI   = 8'd9;
        RANK = 4'd8;
      end
    end
    applyStimulus(down, 4'd8, 1);
    awaitResult("b2b second", 8'd9, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
